// File: rtl/shifter_pkg.sv
// Shared constants for the ALU shifter: data width, shift-amount width and op codes.
// Also provides the bit-reversal helper used to map left shifts onto the right shifter.
package shifter_pkg;

    localparam int WIDTH = 32;
    localparam int SHW   = $clog2(WIDTH);

    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b01;
    localparam logic [1:0] SH_SRA = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shifter_core.sv
// Combinational logarithmic barrel shifter: one right-shift datapath serves all four ops.
// Left shifts run through it bit-reversed; carry-outs are derived straight from A and SH.
module shifter_core
    import shifter_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   sh,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             lco,
    output logic             rco
);

    logic [WIDTH-1:0] stage;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] carry_src;
    logic             fill_bit;
    logic             carry_bit;
    logic             is_left;

    assign is_left  = (op == SH_SLL);
    assign fill_bit = (op == SH_SRA) && a[WIDTH-1];

    // NOTE: blocking assignments here are intentional: stage is rewritten step by step
    // inside one combinational evaluation, and every variable gets a default first.
    always_comb begin
        stage = is_left ? bit_reverse(a) : a;
        nxt   = stage;
        for (int k = 0; k < SHW; k++) begin
            nxt = stage;
            if (sh[k]) begin
                for (int b = 0; b < WIDTH; b++) begin
                    if (b + (1 << k) < WIDTH) begin
                        nxt[b] = stage[b + (1 << k)];
                    end else if (op == SH_ROR) begin
                        nxt[b] = stage[b + (1 << k) - WIDTH];
                    end else begin
                        nxt[b] = fill_bit;
                    end
                end
            end
            stage = nxt;
        end
        result = is_left ? bit_reverse(stage) : stage;
    end

    // In reversed space A[WIDTH-SH] sits at index SH-1, so one selector covers both carries.
    always_comb begin
        carry_src = is_left ? bit_reverse(a) : a;
        carry_bit = 1'b0;
        if (sh != '0) begin
            carry_bit = carry_src[sh - 1'b1];
        end
        lco = is_left && carry_bit;
        rco = !is_left && carry_bit;
    end

endmodule

// File: rtl/shifter.sv
// Registered 32-bit barrel shifter: combinational core followed by one output register stage.
// Synchronous active-high reset clears the result and both carry flags.
module shifter
    import shifter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [SHW-1:0]   SH,
    input  logic [1:0]       S,
    input  logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] AOut,
    output logic             LCO,
    output logic             RCO
);

    logic [WIDTH-1:0] aout_d;
    logic [WIDTH-1:0] aout_q;
    logic             lco_d;
    logic             lco_q;
    logic             rco_d;
    logic             rco_q;

    shifter_core u_core (
        .a      (A),
        .sh     (SH),
        .op     (S),
        .result (aout_d),
        .lco    (lco_d),
        .rco    (rco_d)
    );

    // NOTE: reset is sampled on the clock edge and wins over the freshly computed result.
    always_ff @(posedge clk) begin
        if (rst) begin
            aout_q <= '0;
            lco_q  <= 1'b0;
            rco_q  <= 1'b0;
        end else begin
            aout_q <= aout_d;
            lco_q  <= lco_d;
            rco_q  <= rco_d;
        end
    end

    assign AOut = aout_q;
    assign LCO  = lco_q;
    assign RCO  = rco_q;

endmodule

// File: tb/tb_shifter.sv
// Scoreboard bench for shifter: the driver queues expected results, a monitor checks each
// cycle one edge later. Directed vectors first, then a random stream against a reference model.
module tb_shifter;
    import shifter_pkg::*;

    typedef struct {
        logic [31:0] aout;
        logic        lco;
        logic        rco;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  sh;
    logic [1:0]  s;
    logic [31:0] a;
    logic [31:0] aout;
    logic        lco;
    logic        rco;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    shifter dut (
        .clk  (clk),
        .rst  (rst),
        .SH   (sh),
        .S    (s),
        .A    (a),
        .AOut (aout),
        .LCO  (lco),
        .RCO  (rco)
    );

    task automatic drive(input logic r, input logic [1:0] op, input logic [4:0] amt,
                         input logic [31:0] val, input logic [31:0] e_out,
                         input logic e_lco, input logic e_rco, input string name);
        exp_t e;
        @(negedge clk);
        rst = r;
        s   = op;
        sh  = amt;
        a   = val;
        e.aout = e_out;
        e.lco  = e_lco;
        e.rco  = e_rco;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Reference model written with language shift operators on widened vectors.
    task automatic model(input logic [1:0] op, input logic [4:0] amt, input logic [31:0] val,
                         output logic [31:0] e_out, output logic e_lco, output logic e_rco);
        logic [63:0] left_ext;
        logic [63:0] right_ext;
        logic [63:0] dbl;
        left_ext  = {32'h0, val} << amt;
        right_ext = {val, 32'h0} >> amt;
        dbl       = {val, val} >> amt;
        e_lco = 1'b0;
        e_rco = 1'b0;
        case (op)
            2'b00: begin e_out = val << amt;                    e_lco = left_ext[32];  end
            2'b01: begin e_out = val >> amt;                    e_rco = right_ext[31]; end
            2'b10: begin e_out = 32'($signed(val) >>> amt);     e_rco = right_ext[31]; end
            default: begin e_out = dbl[31:0];                   e_rco = right_ext[31]; end
        endcase
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (aout === e.aout && lco === e.lco && rco === e.rco) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s: got AOut=%h LCO=%b RCO=%b, expected AOut=%h LCO=%b RCO=%b",
                             e.name, aout, lco, rco, e.aout, e.lco, e.rco);
                end
            end
        end
    end

    initial begin : driver
        logic [31:0] e_out;
        logic        e_lco;
        logic        e_rco;
        logic [1:0]  op;
        logic [4:0]  amt;
        logic [31:0] val;
        int          budget;

        rst = 1'b1;
        s   = 2'b00;
        sh  = 5'd0;
        a   = 32'h0;

        drive(1'b1, 2'b01, 5'd5,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, "reset");
        drive(1'b0, 2'b01, 5'd5,  32'hFFFF_FFFF, 32'h07FF_FFFF, 1'b0, 1'b1, "reset_release");
        drive(1'b0, 2'b00, 5'd31, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, "sll_max");
        drive(1'b0, 2'b00, 5'd0,  32'h0FFF_FFFF, 32'h0FFF_FFFF, 1'b0, 1'b0, "sll_zero");
        drive(1'b0, 2'b01, 5'd31, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, "srl_max");
        drive(1'b0, 2'b01, 5'd7,  32'hFFFF_FFF0, 32'h01FF_FFFF, 1'b0, 1'b1, "srl_7");
        drive(1'b0, 2'b01, 5'd1,  32'hFFFF_FFF0, 32'h7FFF_FFF8, 1'b0, 1'b0, "srl_1");
        drive(1'b0, 2'b10, 5'd4,  32'h8000_0018, 32'hF800_0001, 1'b0, 1'b1, "sra_neg");
        drive(1'b0, 2'b10, 5'd4,  32'h7000_0000, 32'h0700_0000, 1'b0, 1'b0, "sra_pos");
        drive(1'b0, 2'b11, 5'd4,  32'h0000_000F, 32'hF000_0000, 1'b0, 1'b1, "ror_4");
        drive(1'b0, 2'b11, 5'd0,  32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, "ror_zero");
        drive(1'b0, 2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "sra_max");
        drive(1'b0, 2'b11, 5'd31, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, "ror_max");
        drive(1'b1, 2'b00, 5'd3,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, "mid_reset");

        for (int i = 0; i < 1000; i++) begin
            op  = 2'($urandom_range(0, 3));
            amt = 5'($urandom_range(0, 31));
            val = $urandom();
            model(op, amt, val, e_out, e_lco, e_rco);
            drive(1'b0, op, amt, val, e_out, e_lco, e_rco, "random");
        end

        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d results still outstanding, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
